multicycle_sequencer: RTL and testbench

//  Multi-cycle control FSM sequencing the shared MIPS datapath (one ALU, one memory port, one regfile

---
 rtl/mips_ctrl_pkg.sv | 48 ++++
 rtl/multicycle_sequencer_opcode_class_decoder.sv | 51 +++++
 rtl/multicycle_sequencer.sv | 175 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and the datapath muxes it steers.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_ERR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_SUBI  = 6'b000011;
  localparam logic [5:0] OP_ANDI  = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b001001;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_SB    = 6'b010001;
  localparam logic [5:0] OP_MOVE  = 6'b100000;
  localparam logic [5:0] OP_BEQ   = 6'b100011;
  localparam logic [5:0] OP_BNE   = 6'b100111;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JAL   = 6'b111001;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_ADD   = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_B_RT   = 2'b00;
  localparam logic [1:0] ALU_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_B_ZERO = 2'b10;

  localparam logic [1:0] REG_DST_RT   = 2'b00;
  localparam logic [1:0] REG_DST_RD   = 2'b01;
  localparam logic [1:0] REG_DST_LINK = 2'b10;

endpackage

// File: rtl/multicycle_sequencer_opcode_class_decoder.sv
// Classifies an opcode into instruction classes and the ALU function it needs.
module opcode_class_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output logic       is_rtype,
  output logic       is_alu_imm,
  output logic       is_move,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_link,
  output logic       is_byte,
  output logic       is_undef,
  output logic [2:0] alu_op
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    is_rtype   = 1'b0;
    is_alu_imm = 1'b0;
    is_move    = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_link    = 1'b0;
    is_byte    = 1'b0;
    is_undef   = 1'b0;
    alu_op     = ALU_ADD;
    unique case (op)
      OP_RTYPE: begin is_rtype = 1'b1; alu_op = ALU_FUNCT; end
      OP_ADDI:  is_alu_imm = 1'b1;
      OP_SUBI:  begin is_alu_imm = 1'b1; alu_op = ALU_SUB; end
      OP_ANDI:  begin is_alu_imm = 1'b1; alu_op = ALU_AND; end
      OP_ORI:   begin is_alu_imm = 1'b1; alu_op = ALU_OR;  end
      OP_SLTI:  begin is_alu_imm = 1'b1; alu_op = ALU_SLT; end
      OP_LW:    is_load = 1'b1;
      OP_LB:    begin is_load = 1'b1; is_byte = 1'b1; end
      OP_SW:    is_store = 1'b1;
      OP_SB:    begin is_store = 1'b1; is_byte = 1'b1; end
      OP_MOVE:  is_move = 1'b1;
      OP_BEQ, OP_BNE: begin is_branch = 1'b1; alu_op = ALU_SUB; end
      OP_J:     is_jump = 1'b1;
      OP_JAL:   begin is_jump = 1'b1; is_link = 1'b1; end
      default:  is_undef = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for a shared-resource MIPS datapath,
// with memory-timeout and illegal-opcode traps and a retired-instruction counter.
module multicycle_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             byte_op,
  output logic [2:0]       alu_op,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             fetch_pend;
  logic             mem_wait;
  logic             tmo_hit;

  logic       is_rtype, is_alu_imm, is_move, is_load, is_store;
  logic       is_branch, is_jump, is_link, is_byte, is_undef;
  logic [2:0] dec_alu_op;
  logic [5:0] dec_op;

  // DECODE must classify the live opcode because op_q only captures it at the end of that cycle.
  assign dec_op = (state_q == ST_DECODE) ? opcode : op_q;

  opcode_class_decoder u_decoder (
    .op         (dec_op),
    .is_rtype   (is_rtype),
    .is_alu_imm (is_alu_imm),
    .is_move    (is_move),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .is_link    (is_link),
    .is_byte    (is_byte),
    .is_undef   (is_undef),
    .alu_op     (dec_alu_op)
  );

  always_comb begin
    state_d    = state_q;
    mem_wait   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_SEQ;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    byte_op    = 1'b0;
    alu_op     = ALU_ADD;
    alu_src_b  = ALU_B_RT;
    reg_write  = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_FETCH: begin
          // Once a read has been issued it is held regardless of run.
          if (run || fetch_pend) begin
            mem_read = 1'b1;
            if (mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
              state_d  = ST_DECODE;
            end else begin
              mem_wait = 1'b1;
            end
          end
        end
        ST_DECODE: begin
          if (is_undef) begin
            state_d = ST_ERR;
          end else if (is_jump) begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JUMP;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
            if (is_link) begin
              reg_write = 1'b1;
              reg_dst   = REG_DST_LINK;
            end
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_op = dec_alu_op;
          if (is_move)                      alu_src_b = ALU_B_ZERO;
          else if (!is_rtype && !is_branch) alu_src_b = ALU_B_IMM;
          if (is_branch) begin
            pc_write   = (op_q == OP_BNE) ? ~zero : zero;
            pc_src     = PC_SRC_BRANCH;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else if (is_load || is_store) begin
            state_d = ST_MEM;
          end else if (is_rtype || is_alu_imm || is_move) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_MEM: begin
          mem_read  = is_load;
          mem_write = is_store;
          byte_op   = is_byte;
          if (mem_ready) begin
            instr_done = is_store;
            state_d    = is_store ? ST_FETCH : ST_WB;
          end else begin
            mem_wait = 1'b1;
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_rtype ? REG_DST_RD : REG_DST_RT;
          mem_to_reg = is_load;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        default: state_d = ST_ERR;
      endcase
    end
    // A completing handshake never counts as a wait, so completion beats the timeout.
    tmo_hit = (MEM_TIMEOUT != 0) && mem_wait && (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));
    if (tmo_hit) state_d = ST_ERR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      op_q        <= '0;
      tmo_cnt     <= '0;
      fetch_pend  <= 1'b0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= state_d;
      fetch_pend <= (state_q == ST_FETCH) && (state_d == ST_FETCH) && mem_wait;
      if (state_q == ST_DECODE) op_q <= opcode;
      if (state_d != state_q)   tmo_cnt <= '0;
      else if (mem_wait)        tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (state_q == ST_DECODE && is_undef) illegal <= 1'b1;
      if (tmo_hit)    bus_err     <= 1'b1;
      if (instr_done) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: per-instruction expected cycle sequences built from the instruction-level
// rules, replayed against the sequencer with randomized memory waits, zero flags and resets.
module tb_multicycle_sequencer;

  localparam int CNT_W = 2;
  localparam int TMO   = 4;

  logic             clk = 1'b0;
  logic             rst_n, run, zero, mem_ready;
  logic [5:0]       opcode;
  logic             pc_write, ir_write, mem_read, mem_write, byte_op;
  logic [1:0]       pc_src, alu_src_b, reg_dst;
  logic [2:0]       alu_op;
  logic             reg_write, mem_to_reg, instr_done, illegal, bus_err;
  logic [CNT_W-1:0] instr_count;

  always #5 clk = ~clk;

  multicycle_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .byte_op(byte_op), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal(illegal), .bus_err(bus_err), .instr_count(instr_count)
  );

  typedef struct {
    logic       rst_n, run, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, ir_write, mem_read, mem_write, byte_op, reg_write, mem_to_reg, instr_done;
    logic [1:0] pc_src, alu_src_b, reg_dst;
    logic [2:0] alu_op;
    bit         care_pc_src, care_alu, care_byte, counts_lat, is_rst, set_illegal, set_bus_err;
    int         pin_lat;
  } cyc_t;

  cyc_t q[$];
  cyc_t cur;
  bit   cur_valid = 1'b0;
  int   checks = 0, errors = 0;
  int   m_cnt = 0, lat = 0;
  bit   m_ill = 1'b0, m_be = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b000111, 6'b001000, 6'b001001,
      6'b010000, 6'b010001, 6'b100000, 6'b100011, 6'b100111, 6'b111000, 6'b111001: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_alu(input logic [5:0] op);
    case (op)
      6'b000100: return 3'b000;
      6'b000101: return 3'b001;
      6'b000111: return 3'b100;
      6'b000011, 6'b100011, 6'b100111: return 3'b110;
      6'b000000: return 3'b111;
      default:   return 3'b101;
    endcase
  endfunction

  function automatic cyc_t blank();
    cyc_t c;
    c = '{default: '0};
    c.rst_n = 1'b1;
    c.run = 1'($urandom);
    c.zero = 1'($urandom);
    c.mem_ready = 1'($urandom);
    c.opcode = 6'($urandom);
    c.counts_lat = 1'b1;
    return c;
  endfunction

  task automatic push_idle(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(); c.run = 1'b0; c.counts_lat = 1'b0; q.push_back(c);
    end
  endtask

  task automatic push_err_tail();
    cyc_t c;
    for (int i = 0; i < 3; i++) begin
      c = blank(); c.counts_lat = 1'b0; q.push_back(c);
    end
  endtask

  task automatic push_reset();
    cyc_t c;
    c = blank(); c.rst_n = 1'b0; c.is_rst = 1'b1; c.counts_lat = 1'b0; q.push_back(c);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction with fw fetch waits and mw memory waits.
  task automatic build_instr(input logic [5:0] op, input logic zv, input int fw, input int mw,
                             input int pin, output bit ended_err);
    cyc_t c;
    bit ld, st, br, jmp;
    ld  = (op == 6'b001000) || (op == 6'b001001);
    st  = (op == 6'b010000) || (op == 6'b010001);
    br  = (op == 6'b100011) || (op == 6'b100111);
    jmp = (op == 6'b111000) || (op == 6'b111001);
    ended_err = 1'b0;
    for (int i = 0; i < fw && i < TMO; i++) begin
      c = blank(); if (i == 0) c.run = 1'b1;
      c.mem_ready = 1'b0; c.mem_read = 1'b1; c.set_bus_err = (i == TMO - 1);
      q.push_back(c);
    end
    if (fw >= TMO) begin push_err_tail(); ended_err = 1'b1; return; end
    c = blank(); if (fw == 0) c.run = 1'b1;
    c.mem_ready = 1'b1; c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
    c.pc_src = 2'b00; c.care_pc_src = 1'b1;
    q.push_back(c);
    c = blank(); c.opcode = op;
    if (!is_legal(op)) begin
      c.set_illegal = 1'b1; q.push_back(c); push_err_tail(); ended_err = 1'b1; return;
    end
    if (jmp) begin
      c.pc_write = 1'b1; c.pc_src = 2'b10; c.care_pc_src = 1'b1; c.instr_done = 1'b1;
      c.pin_lat = pin;
      if (op == 6'b111001) begin c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 1'b0; end
      q.push_back(c); return;
    end
    q.push_back(c);
    c = blank(); c.opcode = op; c.zero = zv; c.care_alu = 1'b1; c.alu_op = exp_alu(op);
    c.alu_src_b = (op == 6'b000000 || br) ? 2'b00 : (op == 6'b100000) ? 2'b10 : 2'b01;
    if (br) begin
      c.pc_write = (op == 6'b100011) ? zv : ~zv; c.pc_src = 2'b01; c.care_pc_src = 1'b1;
      c.instr_done = 1'b1; c.pin_lat = pin; q.push_back(c); return;
    end
    q.push_back(c);
    if (ld || st) begin
      for (int i = 0; i <= mw && i < TMO; i++) begin
        c = blank(); c.opcode = op; c.mem_read = ld; c.mem_write = st; c.care_byte = 1'b1;
        c.byte_op = (op == 6'b001001) || (op == 6'b010001);
        c.mem_ready = (i == mw); c.set_bus_err = (i == TMO - 1) && (i != mw);
        if (i == mw && st) begin c.instr_done = 1'b1; c.pin_lat = pin; end
        q.push_back(c);
      end
      if (mw >= TMO) begin push_err_tail(); ended_err = 1'b1; return; end
      if (st) return;
    end
    c = blank(); c.opcode = op; c.reg_write = 1'b1; c.reg_dst = (op == 6'b000000) ? 2'b01 : 2'b00;
    c.mem_to_reg = ld; c.instr_done = 1'b1; c.pin_lat = pin;
    q.push_back(c);
  endtask

  task automatic run_queue();
    while (q.size() > 0) begin
      @(posedge clk); #1;
      cur = q.pop_front();
      rst_n = cur.rst_n; run = cur.run; zero = cur.zero;
      mem_ready = cur.mem_ready; opcode = cur.opcode;
      cur_valid = 1'b1;
    end
    @(posedge clk); #1;
    cur_valid = 1'b0; rst_n = 1'b1; run = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      check("pc_write", 32'(pc_write), 32'(cur.pc_write));
      check("ir_write", 32'(ir_write), 32'(cur.ir_write));
      check("mem_read", 32'(mem_read), 32'(cur.mem_read));
      check("mem_write", 32'(mem_write), 32'(cur.mem_write));
      check("reg_write", 32'(reg_write), 32'(cur.reg_write));
      check("instr_done", 32'(instr_done), 32'(cur.instr_done));
      if (cur.care_pc_src) check("pc_src", 32'(pc_src), 32'(cur.pc_src));
      if (cur.care_alu) begin
        check("alu_op", 32'(alu_op), 32'(cur.alu_op));
        check("alu_src_b", 32'(alu_src_b), 32'(cur.alu_src_b));
      end
      if (cur.care_byte) check("byte_op", 32'(byte_op), 32'(cur.byte_op));
      if (cur.reg_write) begin
        check("reg_dst", 32'(reg_dst), 32'(cur.reg_dst));
        check("mem_to_reg", 32'(mem_to_reg), 32'(cur.mem_to_reg));
      end
      if (!cur.is_rst) begin
        check("illegal", 32'(illegal), 32'(m_ill));
        check("bus_err", 32'(bus_err), 32'(m_be));
        check("instr_count", 32'(instr_count), 32'(m_cnt));
      end
      if (cur.counts_lat) lat++;
      if (cur.instr_done && cur.pin_lat != 0) check("latency", 32'(lat), 32'(cur.pin_lat));
      if (cur.instr_done || cur.is_rst) lat = 0;
      if (cur.is_rst) begin
        m_cnt = 0; m_ill = 1'b0; m_be = 1'b0;
      end else begin
        if (cur.instr_done) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (cur.set_illegal) m_ill = 1'b1;
        if (cur.set_bus_err) m_be = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ended;
    logic [5:0] legal_ops [15];
    legal_ops = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b000111, 6'b001000,
                  6'b001001, 6'b010000, 6'b010001, 6'b100000, 6'b100011, 6'b100111, 6'b111000,
                  6'b111001};
    rst_n = 1'b0; run = 1'b1; zero = 1'b0; mem_ready = 1'b1; opcode = 6'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mem_read", 32'(mem_read), 32'd0);
    check("reset_pc_write", 32'(pc_write), 32'd0);
    check("reset_count", 32'(instr_count), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);
    check("reset_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b0;
    @(negedge clk);
    check("idle_mem_read", 32'(mem_read), 32'd0);

    // addi, lw with 3 memory waits, taken beq, untaken bne, jal: five retirements wrap 3 -> 0 -> 1.
    push_idle(1);
    build_instr(6'b000010, 1'b0, 0, 0, 4, ended);
    build_instr(6'b001000, 1'b0, 0, 3, 8, ended);
    build_instr(6'b100011, 1'b1, 0, 0, 3, ended);
    build_instr(6'b100111, 1'b1, 0, 0, 3, ended);
    build_instr(6'b111001, 1'b0, 0, 0, 2, ended);
    run_queue();
    check("count_wrap", 32'(instr_count), 32'd1);

    build_instr(6'b111000, 1'b0, 0, 0, 2, ended);
    build_instr(6'b010000, 1'b0, 0, 0, 4, ended);
    build_instr(6'b010001, 1'b0, 2, 1, 7, ended);
    build_instr(6'b001001, 1'b0, 0, 0, 5, ended);
    build_instr(6'b000000, 1'b0, 0, 0, 4, ended);
    build_instr(6'b100000, 1'b0, 0, 0, 4, ended);
    build_instr(6'b000111, 1'b1, 3, 0, 7, ended);
    run_queue();

    build_instr(6'b111111, 1'b0, 0, 0, 0, ended);
    run_queue();
    check("illegal_set", 32'(illegal), 32'd1);
    check("illegal_no_read", 32'(mem_read), 32'd0);
    push_reset();
    run_queue();
    check("illegal_cleared", 32'(illegal), 32'd0);

    build_instr(6'b000010, 1'b0, 4, 0, 0, ended);
    run_queue();
    check("fetch_timeout", 32'(bus_err), 32'd1);
    push_reset();
    run_queue();
    check("bus_err_cleared", 32'(bus_err), 32'd0);

    build_instr(6'b001000, 1'b0, 0, 5, 0, ended);
    push_reset();
    run_queue();

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      int fw, mw;
      op = legal_ops[$urandom_range(0, 14)];
      if ($urandom_range(0, 24) == 0) op = 6'($urandom);
      fw = ($urandom_range(0, 24) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 24) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      push_idle($urandom_range(0, 2));
      build_instr(op, 1'($urandom), fw, mw, 0, ended);
      if (ended) begin
        push_reset();
      end else if ($urandom_range(0, 19) == 0) begin
        int k;
        k = $urandom_range(0, q.size() - 1);
        while (q.size() > k) void'(q.pop_back());
        push_reset();
      end
      run_queue();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
